axi_lite_sram_slave: RTL and testbench
======================================

// Module: axi_lite_sram_slave
// PURPOSE
//  AXI4-Lite slave that terminates the CPU-side AXI-Lite master and backs it with a word-addressed,
//  byte-maskable on-chip SRAM. Independent read and write channel FSMs; one outstanding txn per direction.
//  Sits directly downstream of the master on the same ACLK; decodes a single aligned address window.
// PARAMETERS
//  ADDR_W     32            address width of AW/AR channels
//  DATA_W     32            data width (fixed 32; WSTRB = DATA_W/8)
//  DEPTH      1024          number of DATA_W words in SRAM (power of 2)
//  BASE_ADDR  32'h8000_0000 byte address of word 0; window = BASE_ADDR .. BASE_ADDR+4*DEPTH-1
// PORTS
//  ACLK     in   1        clock, all logic on rising edge
//  ARESETN  in   1        synchronous, active-low reset
//  AWADDR   in   ADDR_W   write address        | AWPROT in 3 accepted, ignored
//  AWVALID  in   1        | AWREADY out 1
//  WDATA    in   DATA_W   | WSTRB in 4 byte enables | WVALID in 1 | WREADY out 1
//  BRESP    out  2        | BVALID out 1 | BREADY in 1
//  ARADDR   in   ADDR_W   | ARVALID in 1 | ARREADY out 1
//  RDATA    out  DATA_W   | RRESP out 2 | RVALID out 1 | RREADY in 1
// BEHAVIOUR
//  Reset (ARESETN=0 at edge): AWREADY=WREADY=ARREADY=0, BVALID=RVALID=0, BRESP=RRESP=2'b00, RDATA=0,
//   both FSMs -> IDLE, captured AW/W flags cleared. SRAM contents NOT cleared. Readies go 1 the cycle after release.
//  Reset mid-transaction: pending txn dropped silently, no B/R response issued, no partial SRAM write.
//  Decode: in-range iff BASE_ADDR <= addr < BASE_ADDR+4*DEPTH; index = (addr-BASE_ADDR)>>2; addr[1:0] ignored.
//  Write FSM {W_IDLE, W_RESP}:
//   - W_IDLE: AWREADY = !aw_held, WREADY = !w_held; AW and W captured independently, either order or same cycle.
//   - When aw_held & w_held (incl. same-cycle capture of both): commit write on next edge, BVALID=1, -> W_RESP.
//     Latency: both handshakes at edge N -> SRAM updated and BVALID high after edge N+1.
//   - In range: bytes with WSTRB[i]=1 written, BRESP=OKAY(00). Out of range: no write, BRESP=DECERR(11).
//   - W_RESP: AWREADY=WREADY=0; BVALID/BRESP held stable until BVALID&BREADY; then clear flags, -> W_IDLE.
//   - WSTRB=4'b0000 in range: legal, no bytes change, BRESP=OKAY.
//  Read FSM {R_IDLE, R_DATA}:
//   - R_IDLE: ARREADY=1; on ARVALID&ARREADY capture ARADDR, SRAM read issued, -> R_DATA.
//   - R_DATA: ARREADY=0; RVALID=1 one cycle after AR handshake (registered SRAM output);
//     RDATA/RRESP held stable until RVALID&RREADY, then -> R_IDLE (next AR accepted the following cycle).
//   - In range: RRESP=OKAY, RDATA=word. Out of range: RRESP=DECERR, RDATA=0.
//  Read/write same cycle, same word: read returns pre-write data (read-before-write); next read sees new data.
//  Valid-before-ready: slave never waits for its own ready to see master valid; no combinational path from
//   any *VALID to any *READY output (all readies registered from FSM state/flags).
//  Back-to-back: max throughput 1 write per 3 cycles, 1 read per 2 cycles with BREADY/RREADY held high.
// STRUCTURE
//  Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
//   typedef enum wr_state_t {W_IDLE,W_RESP}, rd_state_t {R_IDLE,R_DATA}; AXIL_DATA_W=32, AXIL_STRB_W=4.
//  One sub-module: sram_1r1w_bmask (DEPTH x 32, 1 sync read port, 1 sync write port with 4-bit byte mask,
//   read-before-write on address collision). Decode and both FSMs live in the top.
// TESTING
//  1 Reset: hold ARESETN=0 3 cycles with all VALIDs=1 -> all outputs 0; 1 cycle after release AWREADY=WREADY=ARREADY=1.
//  2 Write then read: AW 0x8000_0010 + W 0xDEAD_BEEF strb 4'hF same cycle -> BVALID 2 edges later BRESP=00;
//    AR 0x8000_0010 -> RVALID next cycle, RDATA=0xDEAD_BEEF, RRESP=00.
//  3 Ordering/strobe: W (0x1122_3344, strb 4'b0101) 3 cycles before AW 0x8000_0010 -> WREADY=0 while waiting;
//    readback = 0xDE22_BE44.
//  4 Decode error: AW 0x7FFF_FFFC write 0xFFFF_FFFF -> BRESP=11, SRAM unchanged; AR 0x8000_1000 (DEPTH=1024)
//    -> RRESP=11, RDATA=0.
//  5 Backpressure: BREADY=0 / RREADY=0 for 5 cycles -> BVALID/RVALID, BRESP/RRESP, RDATA stable; no new AW/AR accepted.
//  6 Collision + mid-op reset: same-cycle write 0x0000_0001 and read to 0x8000_0000 (old 0xAAAA_AAAA)
//    -> RDATA=0xAAAA_AAAA, re-read=0x0000_0001; assert reset while BVALID=1 -> BVALID=0, no response after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, channel FSM state types and bus widths.
package axi_lite_pkg;

   localparam int AXIL_DATA_W = 32;
   localparam int AXIL_STRB_W = AXIL_DATA_W / 8;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axi_lite_sram_slave_if.sv
// AXI4-Lite bus bundle between the CPU-side master and the SRAM slave.
interface axi_lite_sram_slave_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   localparam int STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0] AWADDR;
   logic [2:0]        AWPROT;
   logic              AWVALID;
   logic              AWREADY;
   logic [DATA_W-1:0] WDATA;
   logic [STRB_W-1:0] WSTRB;
   logic              WVALID;
   logic              WREADY;
   logic [1:0]        BRESP;
   logic              BVALID;
   logic              BREADY;
   logic [ADDR_W-1:0] ARADDR;
   logic              ARVALID;
   logic              ARREADY;
   logic [DATA_W-1:0] RDATA;
   logic [1:0]        RRESP;
   logic              RVALID;
   logic              RREADY;

   modport master (
      output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

   modport slave (
      input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
      output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
   );

endinterface

// File: rtl/sram_1r1w_bmask.sv
// DEPTH x DATA_W SRAM: one synchronous read port, one synchronous byte-masked write port.
// A read and write to the same word on the same edge returns the pre-write contents.
module sram_1r1w_bmask #(
   parameter int DEPTH  = 1024,
   parameter int DATA_W = 32,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rd_en,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_W-1:0]     rd_data,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [DATA_W/8-1:0]   wr_strb
);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // NOTE: storage arrays carry no reset; contents survive ARESETN and map onto plain RAM macros.
   // NOTE: non-blocking updates make the read below sample mem before this edge's write lands.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < DATA_W / 8; b++) begin
            if (wr_strb[b]) begin
               mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
         end
      end
      if (rd_en) begin
         rd_data_q <= mem[rd_idx];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave backed by a byte-maskable SRAM; independent write and read channel FSMs,
// one outstanding transaction per direction, single aligned decode window.
module axi_lite_sram_slave
   import axi_lite_pkg::*;
#(
   parameter int                ADDR_W    = 32,
   parameter int                DATA_W    = AXIL_DATA_W,
   parameter int                DEPTH     = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic                 ACLK,
   input  logic                 ARESETN,
   axi_lite_sram_slave_if.slave s_axi
);

   localparam int                STRB_W    = DATA_W / 8;
   localparam int                IDX_W     = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(4 * DEPTH);

   function automatic logic in_window(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && (off < WIN_BYTES);
   endfunction

   function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = (addr - BASE_ADDR) >> 2;
      return IDX_W'(off);
   endfunction

   // Write channel state
   wr_state_t         wr_state_q, wr_state_d;
   logic              aw_held_q, aw_held_d;
   logic              w_held_q, w_held_d;
   logic              awready_q, awready_d;
   logic              wready_q, wready_d;
   logic              bvalid_q, bvalid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
   logic [DATA_W-1:0] w_data_q, w_data_d;
   logic [STRB_W-1:0] w_strb_q, w_strb_d;
   logic              wr_commit;

   // Read channel state
   rd_state_t         rd_state_q, rd_state_d;
   logic              arready_q, arready_d;
   logic              rvalid_q, rvalid_d;
   logic [1:0]        rresp_q, rresp_d;
   logic              rd_issue;
   logic [DATA_W-1:0] sram_rd_data;

   // NOTE: every always_comb output gets its default first, so no path can infer a latch.
   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      awready_d  = awready_q;
      wready_d   = wready_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      aw_addr_d  = aw_addr_q;
      w_data_d   = w_data_q;
      w_strb_d   = w_strb_q;
      wr_commit  = 1'b0;

      unique case (wr_state_q)
         W_IDLE: begin
            if (aw_held_q && w_held_q) begin
               wr_commit  = in_window(aw_addr_q);
               bresp_d    = in_window(aw_addr_q) ? RESP_OKAY : RESP_DECERR;
               bvalid_d   = 1'b1;
               awready_d  = 1'b0;
               wready_d   = 1'b0;
               wr_state_d = W_RESP;
            end else begin
               // Readies are re-derived from the held flags so they rise the cycle after reset release.
               if (s_axi.AWVALID && awready_q) begin
                  aw_held_d = 1'b1;
                  aw_addr_d = s_axi.AWADDR;
                  awready_d = 1'b0;
               end else begin
                  awready_d = !aw_held_q;
               end
               if (s_axi.WVALID && wready_q) begin
                  w_held_d = 1'b1;
                  w_data_d = s_axi.WDATA;
                  w_strb_d = s_axi.WSTRB;
                  wready_d = 1'b0;
               end else begin
                  wready_d = !w_held_q;
               end
            end
         end
         W_RESP: begin
            if (bvalid_q && s_axi.BREADY) begin
               bvalid_d   = 1'b0;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               awready_d  = 1'b1;
               wready_d   = 1'b1;
               wr_state_d = W_IDLE;
            end
         end
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      arready_d  = arready_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rd_issue   = 1'b0;

      unique case (rd_state_q)
         R_IDLE: begin
            if (s_axi.ARVALID && arready_q) begin
               rd_issue   = in_window(s_axi.ARADDR);
               rresp_d    = in_window(s_axi.ARADDR) ? RESP_OKAY : RESP_DECERR;
               rvalid_d   = 1'b1;
               arready_d  = 1'b0;
               rd_state_d = R_DATA;
            end else begin
               arready_d = 1'b1;
            end
         end
         R_DATA: begin
            if (rvalid_q && s_axi.RREADY) begin
               rvalid_d   = 1'b0;
               arready_d  = 1'b1;
               rd_state_d = R_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (!ARESETN) begin
         wr_state_q <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rd_state_q <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
      end else begin
         wr_state_q <= wr_state_d;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         awready_q  <= awready_d;
         wready_q   <= wready_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rd_state_q <= rd_state_d;
         arready_q  <= arready_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
      end
   end

   // Payload registers are only consumed while their held flag is set.
   always_ff @(posedge ACLK) begin
      aw_addr_q <= aw_addr_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
   end

   sram_1r1w_bmask #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_sram (
      .clk     (ACLK),
      .rd_en   (rd_issue),
      .rd_idx  (word_idx(s_axi.ARADDR)),
      .rd_data (sram_rd_data),
      .wr_en   (wr_commit && ARESETN),
      .wr_idx  (word_idx(aw_addr_q)),
      .wr_data (w_data_q),
      .wr_strb (w_strb_q)
   );

   assign s_axi.AWREADY = awready_q;
   assign s_axi.WREADY  = wready_q;
   assign s_axi.BVALID  = bvalid_q;
   assign s_axi.BRESP   = bresp_q;
   assign s_axi.ARREADY = arready_q;
   assign s_axi.RVALID  = rvalid_q;
   assign s_axi.RRESP   = rresp_q;
   assign s_axi.RDATA   = (rvalid_q && rresp_q == RESP_OKAY) ? sram_rd_data : '0;

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave: transaction-level model compared every cycle plus literal checks.
module tb_axi_lite_sram_slave;
   import axi_lite_pkg::*;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          TMO   = 50;

   logic ACLK    = 1'b0;
   logic ARESETN = 1'b0;
   always #5 ACLK = ~ACLK;

   axi_lite_sram_slave_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   axi_lite_sram_slave #(
      .ADDR_W    (32),
      .DATA_W    (32),
      .DEPTH     (DEPTH),
      .BASE_ADDR (BASE)
   ) dut (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .s_axi   (bus)
   );

   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   // ---------------- transaction-level model ----------------
   logic [31:0] m_mem [DEPTH];
   bit          m_rdy_on, m_aw_held, m_w_held, m_b_pend, m_r_pend;
   logic [31:0] m_aw_addr, m_w_data, m_r_data;
   logic [3:0]  m_w_strb;
   logic [1:0]  m_b_resp, m_r_resp;

   function automatic bit in_win(input logic [31:0] a);
      return (a >= BASE) && (a < BASE + 32'(4 * DEPTH));
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      return int'((a - BASE) >> 2);
   endfunction

   initial begin : compare
      forever begin
         @(negedge ACLK);
         // Outputs after the last edge must match the model's post-edge state.
         check("awready", 32'(bus.AWREADY), 32'(m_rdy_on && !m_aw_held && !m_b_pend));
         check("wready",  32'(bus.WREADY),  32'(m_rdy_on && !m_w_held && !m_b_pend));
         check("arready", 32'(bus.ARREADY), 32'(m_rdy_on && !m_r_pend));
         check("bvalid",  32'(bus.BVALID),  32'(m_b_pend));
         check("rvalid",  32'(bus.RVALID),  32'(m_r_pend));
         if (m_b_pend) check("bresp", 32'(bus.BRESP), 32'(m_b_resp));
         if (m_r_pend) begin
            check("rresp", 32'(bus.RRESP), 32'(m_r_resp));
            check("rdata", bus.RDATA, m_r_data);
         end
         if (!m_rdy_on) begin
            check("rst_bresp", 32'(bus.BRESP), 32'd0);
            check("rst_rresp", 32'(bus.RRESP), 32'd0);
            check("rst_rdata", bus.RDATA, 32'd0);
         end
         // Advance the model across the coming edge.
         if (!ARESETN) begin
            m_rdy_on = 0; m_aw_held = 0; m_w_held = 0; m_b_pend = 0; m_r_pend = 0;
            m_b_resp = 2'b00; m_r_resp = 2'b00;
         end else begin
            if (m_r_pend) begin
               if (bus.RREADY) m_r_pend = 0;
            end else if (m_rdy_on && bus.ARVALID) begin
               m_r_pend = 1;
               m_r_resp = in_win(bus.ARADDR) ? 2'b00 : 2'b11;
               m_r_data = in_win(bus.ARADDR) ? m_mem[idx_of(bus.ARADDR)] : 32'd0;
            end
            if (m_b_pend) begin
               if (bus.BREADY) begin m_b_pend = 0; m_aw_held = 0; m_w_held = 0; end
            end else if (m_aw_held && m_w_held) begin
               m_b_pend = 1;
               m_b_resp = in_win(m_aw_addr) ? 2'b00 : 2'b11;
               if (in_win(m_aw_addr))
                  for (int b = 0; b < 4; b++)
                     if (m_w_strb[b]) m_mem[idx_of(m_aw_addr)][8*b +: 8] = m_w_data[8*b +: 8];
            end else begin
               if (m_rdy_on && !m_aw_held && bus.AWVALID) begin
                  m_aw_held = 1; m_aw_addr = bus.AWADDR;
               end
               if (m_rdy_on && !m_w_held && bus.WVALID) begin
                  m_w_held = 1; m_w_data = bus.WDATA; m_w_strb = bus.WSTRB;
               end
            end
            m_rdy_on = 1;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic send_aw(input logic [31:0] a);
      bit ok;
      ok = 0;
      bus.AWADDR = a; bus.AWVALID = 1'b1;
      for (int i = 0; i < TMO && !ok; i++) begin @(negedge ACLK); ok = bus.AWREADY; end
      @(posedge ACLK); #1;
      bus.AWVALID = 1'b0;
      check("aw_handshake", 32'(ok), 32'd1);
   endtask

   task automatic send_w(input logic [31:0] d, input logic [3:0] s);
      bit ok;
      ok = 0;
      bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1'b1;
      for (int i = 0; i < TMO && !ok; i++) begin @(negedge ACLK); ok = bus.WREADY; end
      @(posedge ACLK); #1;
      bus.WVALID = 1'b0;
      check("w_handshake", 32'(ok), 32'd1);
   endtask

   task automatic send_ar(input logic [31:0] a);
      bit ok;
      ok = 0;
      bus.ARADDR = a; bus.ARVALID = 1'b1;
      for (int i = 0; i < TMO && !ok; i++) begin @(negedge ACLK); ok = bus.ARREADY; end
      @(posedge ACLK); #1;
      bus.ARVALID = 1'b0;
      check("ar_handshake", 32'(ok), 32'd1);
   endtask

   task automatic wait_b(output logic [1:0] r);
      bit ok;
      ok = 0; r = 2'b00;
      for (int i = 0; i < TMO && !ok; i++) begin
         @(negedge ACLK);
         if (bus.BVALID) begin ok = 1; r = bus.BRESP; end
      end
      @(posedge ACLK); #1;
      check("b_seen", 32'(ok), 32'd1);
   endtask

   task automatic wait_r(output logic [31:0] d, output logic [1:0] r);
      bit ok;
      ok = 0; d = '0; r = 2'b00;
      for (int i = 0; i < TMO && !ok; i++) begin
         @(negedge ACLK);
         if (bus.RVALID) begin ok = 1; d = bus.RDATA; r = bus.RRESP; end
      end
      @(posedge ACLK); #1;
      check("r_seen", 32'(ok), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
      fork
         send_aw(a);
         send_w(d, s);
      join
      wait_b(r);
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
      send_ar(a);
      wait_r(d, r);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed sequence ----------------
   initial begin : main
      logic [31:0] d;
      logic [1:0]  r, br;

      // Reset with every VALID asserted
      bus.AWADDR = 32'h8000_0010; bus.AWPROT = 3'b000; bus.AWVALID = 1'b1;
      bus.WDATA  = 32'h1234_5678; bus.WSTRB  = 4'hF;   bus.WVALID  = 1'b1;
      bus.ARADDR = 32'h8000_0010; bus.ARVALID = 1'b1;
      bus.BREADY = 1'b1;          bus.RREADY  = 1'b1;
      ARESETN = 1'b0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("lit_rst_awready", 32'(bus.AWREADY), 32'd0);
      check("lit_rst_arready", 32'(bus.ARREADY), 32'd0);
      check("lit_rst_bvalid",  32'(bus.BVALID),  32'd0);
      check("lit_rst_rvalid",  32'(bus.RVALID),  32'd0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
      @(negedge ACLK);
      check("lit_release_wready_low", 32'(bus.WREADY), 32'd0);
      @(negedge ACLK);
      check("lit_awready_up", 32'(bus.AWREADY), 32'd1);
      check("lit_wready_up",  32'(bus.WREADY),  32'd1);
      check("lit_arready_up", 32'(bus.ARREADY), 32'd1);
      @(posedge ACLK); #1;

      // Write then read
      do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, br);
      check("lit_wr1_bresp", 32'(br), 32'd0);
      do_read(32'h8000_0010, d, r);
      check("lit_rd1_data", d, 32'hDEAD_BEEF);
      check("lit_rd1_rresp", 32'(r), 32'd0);

      // W leads AW by several cycles, partial strobe
      fork
         send_w(32'h1122_3344, 4'b0101);
         begin
            @(posedge ACLK);
            @(negedge ACLK);
            check("lit_wready_while_waiting", 32'(bus.WREADY), 32'd0);
            @(posedge ACLK); @(posedge ACLK); #1;
            send_aw(32'h8000_0010);
         end
      join
      wait_b(br);
      check("lit_wr2_bresp", 32'(br), 32'd0);
      do_read(32'h8000_0010, d, r);
      check("lit_rd2_merge", d, 32'hDE22_BE44);

      // Decode boundaries
      do_write(32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, br);
      check("lit_below_base_bresp", 32'(br), 32'd3);
      do_read(32'h8000_1000, d, r);
      check("lit_past_end_rresp", 32'(r), 32'd3);
      check("lit_past_end_rdata", d, 32'd0);
      do_read(32'h8000_0010, d, r);
      check("lit_unchanged_after_decerr", d, 32'hDE22_BE44);
      do_write(32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, br);
      check("lit_last_word_bresp", 32'(br), 32'd0);
      do_read(32'h8000_0FFF, d, r);
      check("lit_last_word_unaligned", d, 32'h0BAD_F00D);
      do_write(32'h8000_0FFC, 32'hFFFF_FFFF, 4'h0, br);
      check("lit_zero_strb_bresp", 32'(br), 32'd0);
      do_read(32'h8000_0FFC, d, r);
      check("lit_zero_strb_data", d, 32'h0BAD_F00D);

      // Backpressure on B then R
      bus.BREADY = 1'b0;
      fork
         send_aw(32'h8000_0040);
         send_w(32'h0000_CAFE, 4'hF);
      join
      repeat (6) @(negedge ACLK);
      check("lit_b_stall_bvalid", 32'(bus.BVALID), 32'd1);
      check("lit_b_stall_awready", 32'(bus.AWREADY), 32'd0);
      @(posedge ACLK); #1;
      bus.BREADY = 1'b1;
      wait_b(br);
      bus.RREADY = 1'b0;
      send_ar(32'h8000_0010);
      repeat (5) @(negedge ACLK);
      check("lit_r_stall_rdata", bus.RDATA, 32'hDE22_BE44);
      check("lit_r_stall_arready", 32'(bus.ARREADY), 32'd0);
      @(posedge ACLK); #1;
      bus.RREADY = 1'b1;
      wait_r(d, r);

      // Same-edge write commit and read of one word
      do_write(32'h8000_0000, 32'hAAAA_AAAA, 4'hF, br);
      bus.AWADDR = 32'h8000_0000; bus.AWVALID = 1'b1;
      bus.WDATA  = 32'h0000_0001; bus.WSTRB  = 4'hF; bus.WVALID = 1'b1;
      @(posedge ACLK); #1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      bus.ARADDR = 32'h8000_0000; bus.ARVALID = 1'b1;
      @(posedge ACLK); #1;
      bus.ARVALID = 1'b0;
      fork
         wait_r(d, r);
         wait_b(br);
      join
      check("lit_collision_old", d, 32'hAAAA_AAAA);
      do_read(32'h8000_0000, d, r);
      check("lit_collision_new", d, 32'h0000_0001);

      // Reset while BVALID is pending
      bus.BREADY = 1'b0;
      fork
         send_aw(32'h8000_0000);
         send_w(32'h7777_7777, 4'hF);
      join
      for (int i = 0; i < TMO && !bus.BVALID; i++) @(negedge ACLK);
      @(posedge ACLK); #1;
      ARESETN = 1'b0;
      @(posedge ACLK);
      @(negedge ACLK);
      check("lit_midrst_bvalid", 32'(bus.BVALID), 32'd0);
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      bus.BREADY = 1'b1;
      repeat (5) @(negedge ACLK);
      check("lit_no_b_after_release", 32'(bus.BVALID), 32'd0);
      @(posedge ACLK); #1;
      do_read(32'h8000_0000, d, r);
      check("lit_committed_before_rst", d, 32'h7777_7777);

      // Reset on the commit edge drops the write
      do_write(32'h8000_0020, 32'h5555_5555, 4'hF, br);
      bus.AWADDR = 32'h8000_0020; bus.AWVALID = 1'b1;
      bus.WDATA  = 32'h1234_5678; bus.WSTRB  = 4'hF; bus.WVALID = 1'b1;
      @(posedge ACLK); #1;
      bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
      ARESETN = 1'b0;
      @(posedge ACLK); #1;
      ARESETN = 1'b1;
      do_read(32'h8000_0020, d, r);
      check("lit_dropped_write", d, 32'h5555_5555);

      repeat (3) @(negedge ACLK);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
